// File: rtl/slow_memory_model.sv
// Slow main-memory model: 128-bit lines, fixed access latency, one-cycle ready pulse.
// Optional protocol checker and violation counter enabled by defining SLOWMEM_ERRCHK_EN.
module slow_memory_model #(
    parameter int MEM_NUM = 256,
    parameter int LATENCY = 25,
    parameter int ADDR_W  = 28,
    parameter int DATA_W  = 128
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o
);
    localparam int IDX_W = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                op_rd_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                ready_q;

    logic [DATA_W-1:0]   mem [0:MEM_NUM-1];

    logic [IDX_W-1:0]    idx;
    logic                req_held;
    logic                complete;
    logic                mem_we;

    always_comb begin
        idx      = IDX_W'(addr_q % ADDR_W'(MEM_NUM));
        // Only the request that was accepted keeps the access alive.
        req_held = op_rd_q ? mem_read_i : mem_write_i;
        complete = (state_q == BUSY) && req_held && (cnt_q == CNT_W'(LATENCY));
        mem_we   = complete && !op_rd_q && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_rd_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_read_i || mem_write_i) begin
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        op_rd_q <= mem_read_i;
                        cnt_q   <= CNT_W'(1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_q == CNT_W'(LATENCY)) begin
                        ready_q <= 1'b1;
                        if (op_rd_q) begin
                            rdata_q <= mem[idx];
                        end
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Array storage has no reset so preloaded contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

    assign mem_rdata_o = rdata_q;
    assign mem_ready_o = ready_q;

`ifdef SLOWMEM_ERRCHK_EN
    logic [15:0] viol_cnt_q;
    logic [3:0]  viol;

    always_comb begin
        viol[0] = (state_q == IDLE) && mem_read_i && mem_write_i;
        viol[1] = (state_q == BUSY) && !req_held;
        viol[2] = (state_q == BUSY) && ((mem_addr_i != addr_q) || (mem_wdata_i != wdata_q));
        viol[3] = (state_q == IDLE) && (mem_read_i || mem_write_i)
                  && (mem_addr_i >= ADDR_W'(MEM_NUM));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            viol_cnt_q <= '0;
        end else begin
            viol_cnt_q <= viol_cnt_q + 16'($countones(viol));
            if (viol[0]) $display("[%0t] slow_memory_model: WARNING read and write high together", $time);
            if (viol[1]) $display("[%0t] slow_memory_model: WARNING request dropped while busy", $time);
            if (viol[2]) $display("[%0t] slow_memory_model: WARNING addr/wdata changed while busy", $time);
            if (viol[3]) $display("[%0t] slow_memory_model: WARNING address beyond MEM_NUM", $time);
        end
    end
`endif

endmodule

// File: tb/tb_slow_memory_model.sv
// Scoreboard bench for slow_memory_model: a line-array reference model predicts
// the completion cycle and read data of each access; a monitor checks every ready pulse.
module tb_slow_memory_model;
    localparam int LAT     = 25;
    localparam int MEM_NUM = 256;
    localparam int AW      = 28;
    localparam int DW      = 128;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic [DW-1:0] rdata;
    logic          ready;

    slow_memory_model #(
        .MEM_NUM(MEM_NUM), .LATENCY(LAT), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .mem_read_i  (rd),
        .mem_write_i (wr),
        .mem_addr_i  (addr),
        .mem_wdata_i (wdata),
        .mem_rdata_o (rdata),
        .mem_ready_o (ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] rdata;
        string         name;
    } exp_t;

    exp_t          sb[$];
    exp_t          mon_e;
    logic [DW-1:0] ref_mem [MEM_NUM];
    logic [DW-1:0] last_rdata = '0;
    int            tests = 0;
    int            fails = 0;

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_ready: ready=1 at cycle %0d, required no pulse", cyc);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.cyc != cyc || rdata !== mon_e.rdata) begin
                    fails++;
                    $display("FAIL %s: got cycle=%0d rdata=%h, required cycle=%0d rdata=%h",
                             mon_e.name, cyc, rdata, mon_e.cyc, mon_e.rdata);
                end
            end
        end
    end

    // Reference model: completes at accept+LAT; reads return the line, writes leave rdata alone.
    task automatic push(input bit rdop, input int idx, input logic [DW-1:0] d,
                        input int acc, input string name);
        exp_t e;
        e.cyc  = acc + LAT;
        e.name = name;
        if (rdop) begin
            e.rdata    = ref_mem[idx];
            last_rdata = ref_mem[idx];
        end else begin
            e.rdata      = last_rdata;
            ref_mem[idx] = d;
        end
        sb.push_back(e);
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ready !== 1'b1 && n < LAT + 6);
        if (ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: ready=0 after %0d cycles, required a pulse", name, LAT + 6);
        end
    endtask

    task automatic txn(input bit r, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int abort_at, input string name);
        int acc;
        int idx;
        @(posedge clk);
        #1;
        rd = r; wr = w; addr = a; wdata = d;
        acc = cyc + 1;
        idx = int'(a % AW'(MEM_NUM));
        if (abort_at == 0) push(r, idx, d, acc, name);
        @(posedge clk);
        #1;
        // Changes after accept must be ignored by the memory.
        addr  = AW'($urandom);
        wdata = {4{$urandom}};
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clk);
            #1;
            rd = 1'b0; wr = 1'b0;
            repeat (LAT + 3) @(posedge clk);
        end else begin
            wait_ready(name);
            rd = 1'b0; wr = 1'b0;
        end
        repeat ($urandom_range(1, 3)) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string name);
        tests++;
        if (ready !== 1'b0 || rdata !== '0) begin
            fails++;
            $display("FAIL %s: got ready=%b rdata=%h, required ready=0 rdata=0", name, ready, rdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            acc;
        int            kind;
        int            idx;
        logic [AW-1:0] a;
        logic [DW-1:0] d;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Preload lines 0..15 through the write port.
        for (int i = 0; i < 16; i++) begin
            d = (i == 3) ? {16{8'hA5}} : {$urandom, $urandom, $urandom, $urandom};
            a = (i % 4 == 1) ? {20'($urandom), 8'(i)} : AW'(i);
            txn(1'b0, 1'b1, a, d, 0, "preload");
        end

        txn(1'b1, 1'b0, AW'(3), '0, 0, "read_a5");
        txn(1'b0, 1'b1, AW'(7), DW'(128'h1234), 0, "write_7");
        txn(1'b1, 1'b0, AW'(7), '0, 0, "read_7");

        // Back-to-back: request held through ready, second ready LAT+2 later.
        @(posedge clk);
        #1;
        rd = 1'b1; wr = 1'b0; addr = AW'(3);
        acc = cyc + 1;
        push(1'b1, 3, '0, acc, "b2b_first");
        push(1'b1, 3, '0, acc + LAT + 2, "b2b_second");
        wait_ready("b2b_first");
        wait_ready("b2b_second");
        rd = 1'b0;
        repeat (2) @(posedge clk);

        txn(1'b0, 1'b1, AW'(9), {4{32'hDEADBEEF}}, 10, "abort_write_9");
        txn(1'b1, 1'b0, AW'(9), '0, 0, "read_9_after_abort");

        txn(1'b1, 1'b0, AW'(256 + 5), '0, 0, "read_wrap_261");
        txn(1'b1, 1'b1, AW'(5), {4{32'hCAFEF00D}}, 0, "read_write_priority");
        txn(1'b1, 1'b0, AW'(5), '0, 0, "read_5_unchanged");

        // Reset sampled on the 12th edge of a write.
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b1; addr = AW'(11); wdata = {4{32'h0BADF00D}};
        repeat (12) @(posedge clk);
        #1;
        rst = 1'b1; wr = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_write");
        rst = 1'b0;
        last_rdata = '0;
        repeat (LAT + 2) @(posedge clk);
        txn(1'b1, 1'b0, AW'(11), '0, 0, "read_11_after_reset");

        for (int n = 0; n < 30; n++) begin
            kind = $urandom_range(0, 9);
            idx  = $urandom_range(0, 15);
            a    = ($urandom_range(0, 3) == 0) ? {20'($urandom), 8'(idx)} : AW'(idx);
            d    = {$urandom, $urandom, $urandom, $urandom};
            case (kind)
                0, 1, 2, 3: txn(1'b1, 1'b0, a, d, 0, "rand_read");
                4, 5, 6:    txn(1'b0, 1'b1, a, d, 0, "rand_write");
                7:          txn(1'b1, 1'b1, a, d, 0, "rand_both");
                8:          txn(1'b0, 1'b1, a, d, $urandom_range(1, LAT - 1), "rand_abort_w");
                default:    txn(1'b1, 1'b0, a, d, $urandom_range(1, LAT - 1), "rand_abort_r");
            endcase
        end

        repeat (LAT + 5) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d expectations outstanding, required 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
